// File: rtl/br_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : br_tracker_pkg
// Description : Shared helpers for the quota-based freelist tracker: entry-ID
//               width, count width and shared-pool size computations.
// Revision    : 1.0 - initial release
// ============================================================================
package br_tracker_pkg;

    // Width of an index into n items (at least one bit so a single-item
    // space still has a legal vector).
    function automatic int f_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the values 0..n inclusive.
    function automatic int f_count_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Entries left over once every port has its guaranteed reservation.
    function automatic int f_shared_size(input int entries, input int ports,
                                         input int reserved);
        return entries - (ports * reserved);
    endfunction

endpackage : br_tracker_pkg
`default_nettype wire

// File: rtl/br_tracker_freelist_quota_budget.sv
`default_nettype none
// ============================================================================
// Module      : br_tracker_freelist_quota_budget
// Description : Per-port held-count bookkeeping and grant decision. A port
//               requesting to stage is granted when it is below its
//               reservation, or when it is below its cap and a shared slot
//               is still available this cycle. Shared slots are handed out
//               in fixed priority (port 0 highest) unless
//               BR_TRACKER_FREELIST_QUOTA_RR_ARB_EN is defined, in which case
//               a round-robin pointer picks the starting port.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_req         - per-port stage request (empty or popping)
//               i_dec         - per-port count of entries freed this cycle
//               o_grant       - per-port stage grant
//               o_held        - per-port staged+allocated count (registered)
// Macro       : BR_TRACKER_FREELIST_QUOTA_RR_ARB_EN
// Revision    : 1.0 - initial release
// ============================================================================
module br_tracker_freelist_quota_budget
    import br_tracker_pkg::*;
#(
    parameter int NUM_ENTRIES       = 8,
    parameter int NUM_ALLOC_PORTS   = 2,
    parameter int RESERVED_PER_PORT = 1,
    parameter int MAX_PER_PORT      = NUM_ENTRIES,
    localparam int CW               = f_count_width(NUM_ENTRIES),
    localparam int PW               = f_id_width(NUM_ALLOC_PORTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_ALLOC_PORTS-1:0]          i_req,
    input  logic [NUM_ALLOC_PORTS-1:0][CW-1:0]  i_dec,
    output logic [NUM_ALLOC_PORTS-1:0]          o_grant,
    output logic [NUM_ALLOC_PORTS-1:0][CW-1:0]  o_held
);

    localparam int SHARED_SIZE =
        f_shared_size(NUM_ENTRIES, NUM_ALLOC_PORTS, RESERVED_PER_PORT);

    logic [NUM_ALLOC_PORTS-1:0][CW-1:0] r_held;
    logic [CW-1:0]                      w_shared_used;
    logic [CW-1:0]                      w_shared_avail;
    logic [PW-1:0]                      w_idx;

`ifdef BR_TRACKER_FREELIST_QUOTA_RR_ARB_EN
    logic [PW-1:0]                      r_ptr;
    int                                 w_rr_idx;
    int                                 w_last_idx;
    logic                               w_any_shared;
`endif

    assign o_held = r_held;

    // Shared usage is whatever each port holds beyond its reservation.
    always_comb begin
        w_shared_used = '0;
        for (int i = 0; i < NUM_ALLOC_PORTS; i++) begin
            if (r_held[i] > CW'(RESERVED_PER_PORT)) begin
                w_shared_used = w_shared_used + (r_held[i] - CW'(RESERVED_PER_PORT));
            end
        end
    end

    always_comb begin
        o_grant        = '0;
        w_shared_avail = CW'(SHARED_SIZE) - w_shared_used;
        w_idx          = '0;
`ifdef BR_TRACKER_FREELIST_QUOTA_RR_ARB_EN
        w_rr_idx       = 0;
        w_last_idx     = 0;
        w_any_shared   = 1'b0;
`endif
        // Reserved grants never compete with anything.
        for (int i = 0; i < NUM_ALLOC_PORTS; i++) begin
            if (i_req[i] && (r_held[i] < CW'(RESERVED_PER_PORT))) begin
                o_grant[i] = 1'b1;
            end
        end
        // Shared grants consume the remaining pool in arbitration order.
        for (int k = 0; k < NUM_ALLOC_PORTS; k++) begin
`ifdef BR_TRACKER_FREELIST_QUOTA_RR_ARB_EN
            w_rr_idx = int'(r_ptr) + k;
            if (w_rr_idx >= NUM_ALLOC_PORTS) begin
                w_rr_idx = w_rr_idx - NUM_ALLOC_PORTS;
            end
            w_idx = PW'(w_rr_idx);
`else
            w_idx = PW'(k);
`endif
            if (i_req[w_idx] &&
                (r_held[w_idx] >= CW'(RESERVED_PER_PORT)) &&
                (r_held[w_idx] <  CW'(MAX_PER_PORT)) &&
                (w_shared_avail != '0)) begin
                o_grant[w_idx] = 1'b1;
                w_shared_avail = w_shared_avail - CW'(1);
`ifdef BR_TRACKER_FREELIST_QUOTA_RR_ARB_EN
                w_last_idx   = int'(w_idx);
                w_any_shared = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held <= '0;
        end else begin
            for (int i = 0; i < NUM_ALLOC_PORTS; i++) begin
                r_held[i] <= r_held[i] + CW'(o_grant[i]) - i_dec[i];
            end
        end
    end

`ifdef BR_TRACKER_FREELIST_QUOTA_RR_ARB_EN
    // Pointer moves just past the last port that won a shared slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any_shared) begin
            if (w_last_idx + 1 >= NUM_ALLOC_PORTS) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= PW'(w_last_idx + 1);
            end
        end
    end
`endif

endmodule : br_tracker_freelist_quota_budget
`default_nettype wire

// File: rtl/br_tracker_freelist_quota.sv
`default_nettype none
// ============================================================================
// Module      : br_tracker_freelist_quota
// Description : Multi-port freelist with per-port reservation and a shared
//               pool. Each alloc port owns one staging register that reloads
//               whenever it is empty or popped. Entry ownership is recorded
//               at staging time so deallocation needs only the entry ID.
//               The free vector is registered without bypass: an entry freed
//               in cycle N is staged in N+1 and presented in N+2.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               alloc_ready       - per-port consumer accepts staged entry
//               alloc_valid       - per-port staged entry present
//               alloc_entry_id    - per-port staged entry ID
//               dealloc_valid     - per-dealloc-port free request
//               dealloc_entry_id  - per-dealloc-port entry being freed
//               held_count        - per-port staged+allocated count
//               free_count        - entries neither staged nor allocated
// Macro       : BR_TRACKER_FREELIST_QUOTA_RR_ARB_EN (round-robin shared pool)
// Revision    : 1.0 - initial release
// ============================================================================
module br_tracker_freelist_quota
    import br_tracker_pkg::*;
#(
    parameter int NUM_ENTRIES       = 8,
    parameter int NUM_ALLOC_PORTS   = 2,
    parameter int NUM_DEALLOC_PORTS = 1,
    parameter int RESERVED_PER_PORT = 1,
    parameter int MAX_PER_PORT      = NUM_ENTRIES,
    localparam int ENTRY_ID_WIDTH   = f_id_width(NUM_ENTRIES),
    localparam int COUNT_WIDTH      = f_count_width(NUM_ENTRIES)
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [NUM_ALLOC_PORTS-1:0]                          alloc_ready,
    output logic [NUM_ALLOC_PORTS-1:0]                          alloc_valid,
    output logic [NUM_ALLOC_PORTS-1:0][ENTRY_ID_WIDTH-1:0]      alloc_entry_id,
    input  logic [NUM_DEALLOC_PORTS-1:0]                        dealloc_valid,
    input  logic [NUM_DEALLOC_PORTS-1:0][ENTRY_ID_WIDTH-1:0]    dealloc_entry_id,
    output logic [NUM_ALLOC_PORTS-1:0][COUNT_WIDTH-1:0]         held_count,
    output logic [COUNT_WIDTH-1:0]                              free_count
);

    localparam int EW = ENTRY_ID_WIDTH;
    localparam int CW = COUNT_WIDTH;
    localparam int PW = f_id_width(NUM_ALLOC_PORTS);

    logic [NUM_ENTRIES-1:0]             r_free;
    logic [PW-1:0]                      r_owner [NUM_ENTRIES];
    logic [NUM_ALLOC_PORTS-1:0]         r_valid;
    logic [NUM_ALLOC_PORTS-1:0][EW-1:0] r_id;
    logic [CW-1:0]                      r_free_count;

    logic [NUM_ALLOC_PORTS-1:0]         w_req;
    logic [NUM_ALLOC_PORTS-1:0]         w_grant;
    logic [NUM_ALLOC_PORTS-1:0][CW-1:0] w_held;
    logic [NUM_ALLOC_PORTS-1:0][CW-1:0] w_dec;
    logic [NUM_ENTRIES-1:0]             w_dealloc_mask;
    logic [CW-1:0]                      w_num_dealloc;
    logic [NUM_ENTRIES-1:0]             w_mask;
    logic [NUM_ENTRIES-1:0]             w_push_mask;
    logic [NUM_ALLOC_PORTS-1:0][EW-1:0] w_sel_id;
    logic [NUM_ALLOC_PORTS-1:0]         w_sel_found;
    logic [CW-1:0]                      w_num_grant;
    int                                 w_sum_held;

    assign alloc_valid    = r_valid;
    assign alloc_entry_id = r_id;
    assign held_count     = w_held;
    assign free_count     = r_free_count;

    // A staging register may reload when it is empty or being popped.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_ALLOC_PORTS; i++) begin
            w_req[i] = !r_valid[i] || alloc_ready[i];
        end
    end

    br_tracker_freelist_quota_budget #(
        .NUM_ENTRIES       (NUM_ENTRIES),
        .NUM_ALLOC_PORTS   (NUM_ALLOC_PORTS),
        .RESERVED_PER_PORT (RESERVED_PER_PORT),
        .MAX_PER_PORT      (MAX_PER_PORT)
    ) u_budget (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_req),
        .i_dec   (w_dec),
        .o_grant (w_grant),
        .o_held  (w_held)
    );

    // Each dealloc hit decrements its owner's count; several hits on the
    // same owner in one cycle add up.
    always_comb begin
        w_dec          = '0;
        w_dealloc_mask = '0;
        w_num_dealloc  = '0;
        for (int j = 0; j < NUM_DEALLOC_PORTS; j++) begin
            if (dealloc_valid[j]) begin
                w_dec[r_owner[dealloc_entry_id[j]]] =
                    w_dec[r_owner[dealloc_entry_id[j]]] + CW'(1);
                w_dealloc_mask[dealloc_entry_id[j]] = 1'b1;
                w_num_dealloc = w_num_dealloc + CW'(1);
            end
        end
    end

    // Lowest-index free entry per granted port; lower ports claim first.
    always_comb begin
        w_mask      = r_free;
        w_push_mask = '0;
        w_sel_id    = '0;
        w_sel_found = '0;
        for (int i = 0; i < NUM_ALLOC_PORTS; i++) begin
            if (w_grant[i]) begin
                for (int e = 0; e < NUM_ENTRIES; e++) begin
                    if (!w_sel_found[i] && w_mask[e]) begin
                        w_sel_found[i] = 1'b1;
                        w_sel_id[i]    = EW'(e);
                        w_mask[e]      = 1'b0;
                        w_push_mask[e] = 1'b1;
                    end
                end
            end
        end
    end

    assign w_num_grant = CW'($countones(w_grant));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_free       <= '1;
            r_valid      <= '0;
            r_id         <= '0;
            r_free_count <= CW'(NUM_ENTRIES);
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                r_owner[e] <= '0;
            end
        end else begin
            r_free       <= (r_free & ~w_push_mask) | w_dealloc_mask;
            r_free_count <= r_free_count - w_num_grant + w_num_dealloc;
            for (int i = 0; i < NUM_ALLOC_PORTS; i++) begin
                if (w_grant[i]) begin
                    r_valid[i]          <= 1'b1;
                    r_id[i]             <= w_sel_id[i];
                    r_owner[w_sel_id[i]] <= PW'(i);
                end else if (alloc_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_sum_held = 0;
        for (int i = 0; i < NUM_ALLOC_PORTS; i++) begin
            w_sum_held = w_sum_held + int'(w_held[i]);
        end
    end

    // Integration and implementation checks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(r_free_count) + w_sum_held == NUM_ENTRIES);
            assert ($countones(r_free) == int'(r_free_count));
            assert ((w_push_mask & ~r_free) == '0);
            assert (w_sel_found == w_grant);
            for (int i = 0; i < NUM_ALLOC_PORTS; i++) begin
                if (w_req[i] && (w_held[i] < CW'(RESERVED_PER_PORT))) begin
                    assert (w_grant[i]);
                end
            end
            for (int j = 0; j < NUM_DEALLOC_PORTS; j++) begin
                if (dealloc_valid[j]) begin
                    assert (int'(dealloc_entry_id[j]) < NUM_ENTRIES);
                    assert (!r_free[dealloc_entry_id[j]]);
                    for (int i = 0; i < NUM_ALLOC_PORTS; i++) begin
                        assert (!(r_valid[i] && (r_id[i] == dealloc_entry_id[j])));
                    end
                    for (int k = j + 1; k < NUM_DEALLOC_PORTS; k++) begin
                        assert (!(dealloc_valid[k] &&
                                  (dealloc_entry_id[k] == dealloc_entry_id[j])));
                    end
                end
            end
        end
    end

endmodule : br_tracker_freelist_quota
`default_nettype wire

// File: tb/tb_br_tracker_freelist_quota.sv
`default_nettype none
// ============================================================================
// Module      : tb_br_tracker_freelist_quota
// Description : Self-checking bench. A reference model tracks the owner of
//               every entry and each port's staged entry; held and free
//               counts are derived by counting. Every stimulus cycle pushes
//               the expected next-cycle outputs into a queue that a monitor
//               pops and compares on the falling edge. Directed sequences
//               follow with constant expectations, then randomized traffic.
//               Honours BR_TRACKER_FREELIST_QUOTA_RR_ARB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_br_tracker_freelist_quota;

    localparam int NE     = 8;
    localparam int NP     = 2;
    localparam int ND     = 2;
    localparam int RES    = 2;
    localparam int MAXP   = 6;
    localparam int EW     = 3;
    localparam int CW     = 4;
    localparam int SHARED = NE - NP * RES;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NP-1:0]          alloc_ready;
    logic [NP-1:0]          alloc_valid;
    logic [NP-1:0][EW-1:0]  alloc_entry_id;
    logic [ND-1:0]          dealloc_valid;
    logic [ND-1:0][EW-1:0]  dealloc_entry_id;
    logic [NP-1:0][CW-1:0]  held_count;
    logic [CW-1:0]          free_count;

    always #5 clk = ~clk;

    br_tracker_freelist_quota #(
        .NUM_ENTRIES       (NE),
        .NUM_ALLOC_PORTS   (NP),
        .NUM_DEALLOC_PORTS (ND),
        .RESERVED_PER_PORT (RES),
        .MAX_PER_PORT      (MAXP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_ready      (alloc_ready),
        .alloc_valid      (alloc_valid),
        .alloc_entry_id   (alloc_entry_id),
        .dealloc_valid    (dealloc_valid),
        .dealloc_entry_id (dealloc_entry_id),
        .held_count       (held_count),
        .free_count       (free_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_owner  [NE];   // -1 free, else port holding it (staged or allocated)
    int m_staged [NP];   // -1 empty, else staged entry
    int m_rr;

    typedef struct packed {
        logic                  rst_rec;
        logic [NP-1:0]         valid;
        logic [NP-1:0][EW-1:0] id;
        logic [NP-1:0][CW-1:0] held;
        logic [CW-1:0]         free;
    } exp_t;

    exp_t exp_q[$];
    int   pop0[$];
    int   pop1[$];

    function automatic int m_held(input int p);
        int n = 0;
        for (int e = 0; e < NE; e++) if (m_owner[e] == p) n++;
        return n;
    endfunction

    task automatic model_step(input logic [NP-1:0] rdy, input logic [ND-1:0] dv,
                              input logic [ND-1:0][EW-1:0] did, input bit r);
        exp_t x;
        int   held [NP];
        bit   fre  [NE];
        bit   want [NP];
        bit   gnt  [NP];
        int   used, avail, p, last;
        if (r) begin
            for (int e = 0; e < NE; e++) m_owner[e] = -1;
            for (int q = 0; q < NP; q++) m_staged[q] = -1;
            m_rr = 0;
        end else begin
            for (int q = 0; q < NP; q++) held[q] = m_held(q);
            for (int e = 0; e < NE; e++) fre[e] = (m_owner[e] < 0);
            used = 0;
            for (int q = 0; q < NP; q++) if (held[q] > RES) used += held[q] - RES;
            avail = SHARED - used;
            for (int q = 0; q < NP; q++) if (m_staged[q] >= 0 && rdy[q]) m_staged[q] = -1;
            for (int q = 0; q < NP; q++) begin
                want[q] = (m_staged[q] < 0);
                gnt[q]  = want[q] && (held[q] < RES);
            end
            last = -1;
            for (int k = 0; k < NP; k++) begin
`ifdef BR_TRACKER_FREELIST_QUOTA_RR_ARB_EN
                p = (m_rr + k) % NP;
`else
                p = k;
`endif
                if (want[p] && !gnt[p] && held[p] < MAXP && avail > 0) begin
                    gnt[p] = 1'b1;
                    avail--;
                    last = p;
                end
            end
`ifdef BR_TRACKER_FREELIST_QUOTA_RR_ARB_EN
            if (last >= 0) m_rr = (last + 1) % NP;
`endif
            for (int q = 0; q < NP; q++) begin
                if (gnt[q]) begin
                    for (int e = 0; e < NE; e++) begin
                        if (fre[e] && m_staged[q] < 0) begin
                            fre[e] = 1'b0;
                            m_owner[e] = q;
                            m_staged[q] = e;
                        end
                    end
                end
            end
            // Freed entries only become stageable on the following step.
            for (int j = 0; j < ND; j++) if (dv[j]) m_owner[did[j]] = -1;
        end
        x.rst_rec = r;
        x.free    = '0;
        for (int q = 0; q < NP; q++) begin
            x.valid[q] = (m_staged[q] >= 0);
            x.id[q]    = (m_staged[q] >= 0) ? EW'(m_staged[q]) : '0;
            x.held[q]  = CW'(m_held(q));
        end
        for (int e = 0; e < NE; e++) if (m_owner[e] < 0) x.free = x.free + CW'(1);
        exp_q.push_back(x);
    endtask

    // ---------------- monitor ----------------
    exp_t mon_x;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            for (int q = 0; q < NP; q++) begin
                check($sformatf("alloc_valid[%0d]", q), int'(alloc_valid[q]), int'(mon_x.valid[q]));
                if (mon_x.valid[q] || mon_x.rst_rec)
                    check($sformatf("alloc_entry_id[%0d]", q), int'(alloc_entry_id[q]), int'(mon_x.id[q]));
                check($sformatf("held_count[%0d]", q), int'(held_count[q]), int'(mon_x.held[q]));
            end
            check("free_count", int'(free_count), int'(mon_x.free));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [NP-1:0] rdy, input logic [ND-1:0] dv,
                         input logic [ND-1:0][EW-1:0] did, input bit r);
        rst              = r;
        alloc_ready      = rdy;
        dealloc_valid    = dv;
        dealloc_entry_id = did;
        if (!r && rdy[0] && alloc_valid[0] === 1'b1) pop0.push_back(int'(alloc_entry_id[0]));
        if (!r && rdy[1] && alloc_valid[1] === 1'b1) pop1.push_back(int'(alloc_entry_id[1]));
        model_step(rdy, dv, did, r);
        @(negedge clk);
    endtask

    task automatic check_reset_release();
        check("rel valid", int'(alloc_valid), 3);
        check("rel id0", int'(alloc_entry_id[0]), 0);
        check("rel id1", int'(alloc_entry_id[1]), 1);
        check("rel free", int'(free_count), 6);
        check("rel held0", int'(held_count[0]), 1);
        check("rel held1", int'(held_count[1]), 1);
    endtask

    int exp_pop0 [6] = '{0, 2, 3, 4, 5, 6};
    logic [NP-1:0]         s_rdy;
    logic [ND-1:0]         s_dv;
    logic [ND-1:0][EW-1:0] s_did;
    bit                    s_rst;
    int                    cand[$];
    int                    pick;

    initial begin
        rst = 1'b1; alloc_ready = '0; dealloc_valid = '0; dealloc_entry_id = '0;
        drive(2'b00, 2'b00, '0, 1'b1);
        drive(2'b00, 2'b00, '0, 1'b1);
        check("reset valid", int'(alloc_valid), 0);
        check("reset free", int'(free_count), NE);

        // Reset release
        drive(2'b00, 2'b00, '0, 1'b0);
        check_reset_release();

        // Greedy port 0
        repeat (6) drive(2'b01, 2'b00, '0, 1'b0);
        check("greedy valid", int'(alloc_valid), 2);
        check("greedy held0", int'(held_count[0]), 6);
        check("greedy free", int'(free_count), 1);
        check("greedy pops", pop0.size(), 6);
        for (int k = 0; k < 6 && k < pop0.size(); k++)
            check($sformatf("greedy pop%0d", k), pop0[k], exp_pop0[k]);

        // Reservation of port 1 honoured
        repeat (2) drive(2'b11, 2'b00, '0, 1'b0);
        check("resv valid", int'(alloc_valid), 0);
        check("resv held1", int'(held_count[1]), 2);
        check("resv free", int'(free_count), 0);
        check("resv pops", pop1.size(), 2);
        if (pop1.size() == 2) begin
            check("resv pop0", pop1[0], 1);
            check("resv pop1", pop1[1], 7);
        end

        // Dealloc latency: freed in N, presented in N+2
        drive(2'b11, 2'b01, {3'd0, 3'd3}, 1'b0);
        check("lat N+1 valid0", int'(alloc_valid[0]), 0);
        check("lat N+1 held0", int'(held_count[0]), 5);
        drive(2'b00, 2'b00, '0, 1'b0);
        check("lat N+2 valid0", int'(alloc_valid[0]), 1);
        check("lat N+2 id0", int'(alloc_entry_id[0]), 3);
        check("lat N+2 held0", int'(held_count[0]), 6);

        // Shared contention with one shared slot left
        drive(2'b00, 2'b00, '0, 1'b1);
        drive(2'b00, 2'b00, '0, 1'b0);
        drive(2'b11, 2'b00, '0, 1'b0);
        drive(2'b11, 2'b00, '0, 1'b0);
        drive(2'b01, 2'b00, '0, 1'b0);
        drive(2'b11, 2'b00, '0, 1'b0);
`ifdef BR_TRACKER_FREELIST_QUOTA_RR_ARB_EN
        check("contend valid", int'(alloc_valid), 2);
        check("contend id1", int'(alloc_entry_id[1]), 7);
        check("contend held1", int'(held_count[1]), 4);
`else
        check("contend valid", int'(alloc_valid), 1);
        check("contend id0", int'(alloc_entry_id[0]), 7);
        check("contend held0", int'(held_count[0]), 5);
`endif
        check("contend free", int'(free_count), 0);

        // Mid-run reset
        drive(2'b00, 2'b00, '0, 1'b1);
        drive(2'b00, 2'b00, '0, 1'b0);
        check_reset_release();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            s_rdy = NP'($urandom_range(0, 3));
            s_rst = ($urandom_range(0, 249) == 0);
            s_dv  = '0;
            s_did = '0;
            cand.delete();
            for (int e = 0; e < NE; e++)
                if (m_owner[e] >= 0 && m_staged[m_owner[e]] != e) cand.push_back(e);
            if (!s_rst) begin
                for (int j = 0; j < ND; j++) begin
                    if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                        pick     = $urandom_range(0, cand.size() - 1);
                        s_dv[j]  = 1'b1;
                        s_did[j] = EW'(cand[pick]);
                        cand.delete(pick);
                    end
                end
            end
            drive(s_rdy, s_dv, s_did, s_rst);
        end

        drive(2'b00, 2'b00, '0, 1'b0);
        #1;
        check("scoreboard drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_br_tracker_freelist_quota
`default_nettype wire
